voice_alloc: RTL and testbench

Polyphonic voice allocator between the MIDI parser and a bank of `nco` oscillators. It accepts decoded note-on/note-off events and assigns each note to one of `VOICES` oscillator slots. When every slot is in use, it steals the least-recently-assigned voice. It also drives per-voice note, velocity, gate and trigger buses, turning the single-voice synth into a polyphonic one.

---
 rtl/voice_alloc_pkg.sv | 19 +
 rtl/voice_lru.sv | 53 +++++
 rtl/voice_alloc.sv | 201 ++++++++++++++++++++
 tb/tb_voice_alloc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_alloc_pkg.sv
// Shared definitions for the polyphonic voice blocks: field widths,
// allocator FSM encoding and the note-on qualification rule.
package voice_alloc_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // A note-on carrying velocity zero is a note-off in MIDI running-status practice.
  function automatic logic is_note_on(input logic on, input logic [VEL_W-1:0] vel);
    return on && (vel != {VEL_W{1'b0}});
  endfunction

endpackage

// File: rtl/voice_lru.sv
// Least-recently-assigned rank keeper: rank 0 is newest, VOICES-1 is oldest.
// Ranks stay a permutation because only ranks below the target's are bumped.
module voice_lru #(
  parameter int VOICES = 4,
  parameter int VW     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ce_i,
  input  logic                 upd_i,
  input  logic [VW-1:0]        tgt_i,
  output logic [VOICES*VW-1:0] rank_o
);

  localparam logic [VW-1:0] ONE = VW'(1);

  logic [VW-1:0] rank_q [VOICES];
  logic [VW-1:0] rank_d [VOICES];
  logic [VW-1:0] tgt_rank_s;

  // Next-rank computation: target to front, younger voices age by one.
  always_comb begin
    tgt_rank_s = rank_q[tgt_i];
    rank_d     = rank_q;
    for (int i = 0; i < VOICES; i++) begin
      if (upd_i) begin
        if (VW'(i) == tgt_i) begin
          rank_d[i] = {VW{1'b0}};
        end else if (rank_q[i] < tgt_rank_s) begin
          rank_d[i] = rank_q[i] + ONE;
        end else begin
          rank_d[i] = rank_q[i];
        end
      end else begin
        rank_d[i] = rank_q[i];
      end
    end
  end

  // Rank registers, reset to identity order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < VOICES; i++) rank_q[i] <= VW'(i);
    end else if (ce_i) begin
      rank_q <= rank_d;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_rank
    assign rank_o[g*VW +: VW] = rank_q[g];
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans all voices per event, then retriggers a
// matching voice, fills a free one, or steals the least recently assigned.
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int VW     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ce_i,
  input  logic                     ev_valid_i,
  output logic                     ev_ready_o,
  input  logic                     ev_on_i,
  input  logic [NOTE_W-1:0]        ev_note_i,
  input  logic [VEL_W-1:0]         ev_vel_i,
  output logic [VOICES*NOTE_W-1:0] voice_note_o,
  output logic [VOICES*VEL_W-1:0]  voice_vel_o,
  output logic [VOICES-1:0]        voice_gate_o,
  output logic [VOICES-1:0]        voice_trig_o,
  output logic                     stolen_o
);

  localparam logic [VW-1:0] ONE  = VW'(1);
  localparam logic [VW-1:0] LAST = VW'(VOICES - 1);

  state_e              state_q, state_d;
  logic [VW-1:0]       idx_q, idx_d;
  logic                on_q, on_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic                match_hit_q, match_hit_d;
  logic [VW-1:0]       match_idx_q, match_idx_d;
  logic                free_hit_q, free_hit_d;
  logic [VW-1:0]       free_idx_q, free_idx_d;
  logic [VW-1:0]       old_idx_q, old_idx_d;
  logic [NOTE_W-1:0]   vnote_q [VOICES];
  logic [NOTE_W-1:0]   vnote_d [VOICES];
  logic [VEL_W-1:0]    vvel_q [VOICES];
  logic [VEL_W-1:0]    vvel_d [VOICES];
  logic [VOICES-1:0]   gate_q, gate_d;
  logic [VOICES-1:0]   trig_q, trig_d;
  logic                stolen_q, stolen_d;

  logic                lru_upd_s;
  logic [VW-1:0]       tgt_s;
  logic [VOICES*VW-1:0] lru_rank_s;
  logic [VW-1:0]       idx_rank_s;

  voice_lru #(.VOICES(VOICES), .VW(VW)) u_lru (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ce_i   (ce_i),
    .upd_i  (lru_upd_s),
    .tgt_i  (tgt_s),
    .rank_o (lru_rank_s)
  );

  // Rank of the voice currently under the scan pointer.
  always_comb begin
    idx_rank_s = {VW{1'b0}};
    for (int i = 0; i < VOICES; i++) begin
      if (VW'(i) == idx_q) begin
        idx_rank_s = lru_rank_s[i*VW +: VW];
      end else begin
        idx_rank_s = idx_rank_s;
      end
    end
  end

  // FSM next state, scan bookkeeping and commit of the chosen voice.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    vel_d       = vel_q;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
    old_idx_d   = old_idx_q;
    vnote_d     = vnote_q;
    vvel_d      = vvel_q;
    gate_d      = gate_q;
    trig_d      = {VOICES{1'b0}};
    stolen_d    = 1'b0;
    lru_upd_s   = 1'b0;
    tgt_s       = {VW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (ev_valid_i) begin
          on_d        = is_note_on(ev_on_i, ev_vel_i);
          note_d      = ev_note_i;
          vel_d       = ev_vel_i;
          idx_d       = {VW{1'b0}};
          match_hit_d = 1'b0;
          free_hit_d  = 1'b0;
          state_d     = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!match_hit_q && gate_q[idx_q] && (vnote_q[idx_q] == note_q)) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end else begin
          match_hit_d = match_hit_q;
        end
        if (!free_hit_q && !gate_q[idx_q]) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end else begin
          free_hit_d = free_hit_q;
        end
        if (idx_rank_s == LAST) begin
          old_idx_d = idx_q;
        end else begin
          old_idx_d = old_idx_q;
        end
        if (idx_q == LAST) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      ST_COMMIT: begin
        if (on_q) begin
          tgt_s          = match_hit_q ? match_idx_q : (free_hit_q ? free_idx_q : old_idx_q);
          vnote_d[tgt_s] = note_q;
          vvel_d[tgt_s]  = vel_q;
          gate_d[tgt_s]  = 1'b1;
          trig_d[tgt_s]  = 1'b1;
          stolen_d       = !match_hit_q && !free_hit_q;
          lru_upd_s      = 1'b1;
        end else if (match_hit_q) begin
          gate_d[match_idx_q] = 1'b0;
        end else begin
          gate_d = gate_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and voice registers; pulses drop on the next edge even with CE low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= {VW{1'b0}};
      on_q        <= 1'b0;
      note_q      <= {NOTE_W{1'b0}};
      vel_q       <= {VEL_W{1'b0}};
      match_hit_q <= 1'b0;
      match_idx_q <= {VW{1'b0}};
      free_hit_q  <= 1'b0;
      free_idx_q  <= {VW{1'b0}};
      old_idx_q   <= {VW{1'b0}};
      for (int i = 0; i < VOICES; i++) begin
        vnote_q[i] <= {NOTE_W{1'b0}};
        vvel_q[i]  <= {VEL_W{1'b0}};
      end
      gate_q      <= {VOICES{1'b0}};
      trig_q      <= {VOICES{1'b0}};
      stolen_q    <= 1'b0;
    end else begin
      trig_q   <= ce_i ? trig_d : {VOICES{1'b0}};
      stolen_q <= ce_i & stolen_d;
      if (ce_i) begin
        state_q     <= state_d;
        idx_q       <= idx_d;
        on_q        <= on_d;
        note_q      <= note_d;
        vel_q       <= vel_d;
        match_hit_q <= match_hit_d;
        match_idx_q <= match_idx_d;
        free_hit_q  <= free_hit_d;
        free_idx_q  <= free_idx_d;
        old_idx_q   <= old_idx_d;
        vnote_q     <= vnote_d;
        vvel_q      <= vvel_d;
        gate_q      <= gate_d;
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign voice_note_o[g*NOTE_W +: NOTE_W] = vnote_q[g];
    assign voice_vel_o[g*VEL_W +: VEL_W]    = vvel_q[g];
  end

  assign voice_gate_o = gate_q;
  assign voice_trig_o = trig_q;
  assign stolen_o     = stolen_q;
  assign ev_ready_o   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc with VOICES=4: allocation, stealing, release,
// velocity-zero, retrigger, mid-scan reset and CE stall.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        rst_n, ce, ev_valid, ev_on, ev_ready;
  logic [6:0]  ev_note, ev_vel;
  logic [27:0] voice_note, voice_vel;
  logic [3:0]  voice_gate, voice_trig;
  logic        stolen;

  int nvec = 0;
  int nerr = 0;

  logic [6:0] exp_note [4];
  logic [6:0] exp_vel  [4];
  logic [3:0] exp_gate;

  int         lat, rdy_low;
  logic [3:0] early_trig, trig_at, post_trig;
  logic       early_st, st_at, post_st;

  voice_alloc #(.VOICES(4), .VW(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ce_i         (ce),
    .ev_valid_i   (ev_valid),
    .ev_ready_o   (ev_ready),
    .ev_on_i      (ev_on),
    .ev_note_i    (ev_note),
    .ev_vel_i     (ev_vel),
    .voice_note_o (voice_note),
    .voice_vel_o  (voice_vel),
    .voice_gate_o (voice_gate),
    .voice_trig_o (voice_trig),
    .stolen_o     (stolen)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] pk_note();
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[i*7 +: 7] = exp_note[i];
    return r;
  endfunction

  function automatic logic [27:0] pk_vel();
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[i*7 +: 7] = exp_vel[i];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      exp_note[i] = 7'd0;
      exp_vel[i]  = 7'd0;
    end
    exp_gate = 4'b0000;
  endtask

  // Drives one event from idle and records what is seen up to one cycle past commit.
  task automatic do_event(input logic on, input logic [6:0] n, input logic [6:0] v);
    lat = -1; rdy_low = 0; early_trig = 4'b0000; early_st = 1'b0;
    trig_at = 4'b0000; st_at = 1'b0;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = on; ev_note = n; ev_vel = v;
    @(posedge clk); #1;
    ev_valid = 1'b0;
    if (!ev_ready) rdy_low++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ev_ready) begin
        lat = k; trig_at = voice_trig; st_at = stolen;
        break;
      end
      rdy_low++;
      early_trig |= voice_trig;
      early_st   |= stolen;
    end
    @(posedge clk); #1;
    post_trig = voice_trig; post_st = stolen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 7'd0; ev_vel = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    #1;
    nvec++; if (ev_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
    nvec++; if ({voice_gate, voice_trig, stolen} !== 9'd0) begin nerr++; $display("FAIL reset_ctl: got %h want 0", {voice_gate, voice_trig, stolen}); end
    nvec++; if ({voice_note, voice_vel} !== 56'd0) begin nerr++; $display("FAIL reset_bus: got %h want 0", {voice_note, voice_vel}); end
    nvec++; if (dut.u_lru.rank_o !== 8'he4) begin nerr++; $display("FAIL reset_rank: got %h want e4", dut.u_lru.rank_o); end
  endtask

  task automatic test_single();
    do_event(1'b1, 7'd60, 7'd100);
    exp_note[0] = 7'd60; exp_vel[0] = 7'd100; exp_gate = 4'b0001;
    nvec++; if (lat !== 5) begin nerr++; $display("FAIL single_latency: got %0d want 5", lat); end
    nvec++; if (rdy_low !== 5) begin nerr++; $display("FAIL single_ready_low: got %0d want 5", rdy_low); end
    nvec++; if ({early_trig, early_st} !== 5'd0) begin nerr++; $display("FAIL single_early: got %h want 0", {early_trig, early_st}); end
    nvec++; if ({trig_at, st_at} !== 5'b0001_0) begin nerr++; $display("FAIL single_trig: got %b want 00010", {trig_at, st_at}); end
    nvec++; if ({post_trig, post_st} !== 5'd0) begin nerr++; $display("FAIL single_pulse_width: got %b want 0", {post_trig, post_st}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL single_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
  endtask

  task automatic test_steal();
    do_event(1'b1, 7'd62, 7'd101);
    nvec++; if ({trig_at, st_at} !== 5'b0010_0) begin nerr++; $display("FAIL fill1_trig: got %b want 00100", {trig_at, st_at}); end
    do_event(1'b1, 7'd64, 7'd102);
    nvec++; if ({trig_at, st_at} !== 5'b0100_0) begin nerr++; $display("FAIL fill2_trig: got %b want 01000", {trig_at, st_at}); end
    do_event(1'b1, 7'd65, 7'd103);
    nvec++; if ({trig_at, st_at} !== 5'b1000_0) begin nerr++; $display("FAIL fill3_trig: got %b want 10000", {trig_at, st_at}); end
    nvec++; if (voice_gate !== 4'b1111) begin nerr++; $display("FAIL fill_gate: got %b want 1111", voice_gate); end
    do_event(1'b1, 7'd67, 7'd104);
    exp_note[0] = 7'd67; exp_vel[0] = 7'd104;
    exp_note[1] = 7'd62; exp_vel[1] = 7'd101;
    exp_note[2] = 7'd64; exp_vel[2] = 7'd102;
    exp_note[3] = 7'd65; exp_vel[3] = 7'd103;
    exp_gate = 4'b1111;
    nvec++; if ({trig_at, st_at} !== 5'b0001_1) begin nerr++; $display("FAIL steal_trig: got %b want 00011", {trig_at, st_at}); end
    nvec++; if ({post_trig, post_st, early_trig, early_st} !== 10'd0) begin nerr++; $display("FAIL steal_pulse: got %b want 0", {post_trig, post_st, early_trig, early_st}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL steal_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'h6c) begin nerr++; $display("FAIL steal_rank: got %h want 6c", dut.u_lru.rank_o); end
  endtask

  task automatic test_release();
    do_event(1'b0, 7'd62, 7'd0);
    exp_gate = 4'b1101;
    nvec++; if ({early_trig, trig_at, post_trig, early_st, st_at, post_st} !== 15'd0) begin
      nerr++; $display("FAIL release_pulse: got %h want 0", {early_trig, trig_at, post_trig, early_st, st_at, post_st}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL release_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'h6c) begin nerr++; $display("FAIL release_rank: got %h want 6c", dut.u_lru.rank_o); end
    do_event(1'b1, 7'd69, 7'd105);
    exp_note[1] = 7'd69; exp_vel[1] = 7'd105; exp_gate = 4'b1111;
    nvec++; if ({trig_at, st_at} !== 5'b0010_0) begin nerr++; $display("FAIL reuse_trig: got %b want 00100", {trig_at, st_at}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL reuse_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'hb1) begin nerr++; $display("FAIL reuse_rank: got %h want b1", dut.u_lru.rank_o); end
  endtask

  task automatic test_velzero();
    do_event(1'b1, 7'd64, 7'd0);
    exp_gate = 4'b1011;
    nvec++; if ({trig_at, st_at, early_trig, early_st} !== 10'd0) begin nerr++; $display("FAIL velzero_pulse: got %b want 0", {trig_at, st_at, early_trig, early_st}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL velzero_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    do_event(1'b0, 7'd50, 7'd64);
    nvec++; if ({early_trig, trig_at, post_trig, early_st, st_at, post_st} !== 15'd0) begin
      nerr++; $display("FAIL unmatched_pulse: got %h want 0", {early_trig, trig_at, post_trig, early_st, st_at, post_st}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL unmatched_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'hb1) begin nerr++; $display("FAIL unmatched_rank: got %h want b1", dut.u_lru.rank_o); end
  endtask

  task automatic test_retrigger();
    do_event(1'b1, 7'd67, 7'd30);
    exp_vel[0] = 7'd30;
    nvec++; if ({trig_at, st_at} !== 5'b0001_0) begin nerr++; $display("FAIL retrig_trig: got %b want 00010", {trig_at, st_at}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL retrig_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'hb4) begin nerr++; $display("FAIL retrig_rank: got %h want b4", dut.u_lru.rank_o); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] seen;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd70; ev_vel = 7'd50;
    @(posedge clk); #1; ev_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    model_clear();
    nvec++; if ({voice_gate, voice_trig, stolen, voice_note, voice_vel} !== 65'd0) begin
      nerr++; $display("FAIL midreset_outputs: got %h want 0", {voice_gate, voice_trig, stolen, voice_note, voice_vel}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    nvec++; if (ev_ready !== 1'b1) begin nerr++; $display("FAIL midreset_ready: got %b want 1", ev_ready); end
    seen = 5'd0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= {voice_trig, stolen};
    end
    nvec++; if (seen !== 5'd0 || voice_gate !== 4'b0000) begin nerr++; $display("FAIL midreset_quiet: got %b/%b want 0", seen, voice_gate); end
    nvec++; if (dut.u_lru.rank_o !== 8'he4) begin nerr++; $display("FAIL midreset_rank: got %h want e4", dut.u_lru.rank_o); end
  endtask

  task automatic test_ce_stall();
    lat = -1; early_trig = 4'b0000; trig_at = 4'b0000; st_at = 1'b0;
    @(negedge clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
    @(posedge clk); #1; ev_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin @(negedge clk); ce = 1'b0; end
      if (k == 13) begin @(negedge clk); ce = 1'b1; end
      @(posedge clk); #1;
      if (ev_ready) begin
        lat = k; trig_at = voice_trig; st_at = stolen;
        break;
      end
      early_trig |= voice_trig;
    end
    exp_note[0] = 7'd60; exp_vel[0] = 7'd100; exp_gate = 4'b0001;
    nvec++; if (lat !== 15) begin nerr++; $display("FAIL ce_latency: got %0d want 15", lat); end
    nvec++; if ({early_trig, trig_at, st_at} !== 9'b0000_0001_0) begin nerr++; $display("FAIL ce_trig: got %b want 000000010", {early_trig, trig_at, st_at}); end
    nvec++; if (voice_note !== pk_note() || voice_vel !== pk_vel() || voice_gate !== exp_gate) begin
      nerr++; $display("FAIL ce_voice: got %h/%h/%b want %h/%h/%b", voice_note, voice_vel, voice_gate, pk_note(), pk_vel(), exp_gate); end
    @(negedge clk); ce = 1'b0;
    @(posedge clk); #1;
    nvec++; if ({voice_trig, stolen} !== 5'd0 || voice_gate !== 4'b0001) begin
      nerr++; $display("FAIL ce_pulse_clear: got %b/%b want 00000/0001", {voice_trig, stolen}, voice_gate); end
    @(negedge clk); ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_steal();
    test_release();
    test_velzero();
    test_retrigger();
    test_reset_mid();
    test_ce_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
